// File: rtl/cr_huf_compPKG.sv
// Shared compressor Huffman constants and types: predefined-table memory
// write interface, load-beat header field offsets and loader FSM states.
package cr_huf_compPKG;

  localparam int PREDET_NUM_ID       = 10;
  localparam int PREDET_LONG_ENTRIES = 22;
  localparam int PREDET_SHRT_ENTRIES = 48;
  localparam int PREDET_ENTRY_W      = 60;
  localparam int PREDET_ID_W         = 4;
  localparam int PREDET_ADDR_W       = 6;
  localparam int PREDET_LD_W         = 64;

  // Header beat field offsets within ld_data.
  localparam int PREDET_HDR_ID_LSB   = 0;
  localparam int PREDET_HDR_ID_MSB   = PREDET_HDR_ID_LSB + PREDET_ID_W - 1;
  localparam int PREDET_HDR_TYPE_BIT = 4;

  // Table type carried in the header type bit.
  localparam logic PREDET_TYPE_LONG = 1'b0;
  localparam logic PREDET_TYPE_SHRT = 1'b1;

  typedef struct packed {
    logic                      wr;
    logic [PREDET_ID_W-1:0]    mem_id;
    logic [PREDET_ADDR_W-1:0]  addr;
    logic [PREDET_ENTRY_W-1:0] data;
  } s_sm_predet_mem_intf;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_FREE = 2'd1,
    ST_LOAD      = 2'd2,
    ST_DROP      = 2'd3
  } e_predet_ld_state;

  // Index of the final entry of a table of the given type.
  function automatic logic [PREDET_ADDR_W-1:0] predet_last_idx(input logic tbl_type,
                                                               input int   n_long,
                                                               input int   n_shrt);
    return (tbl_type == PREDET_TYPE_SHRT) ? PREDET_ADDR_W'(n_shrt - 1)
                                          : PREDET_ADDR_W'(n_long - 1);
  endfunction

endpackage

// File: rtl/cr_huf_comp_predet_ld.sv
// Predefined Huffman table loader. Converts a ready/valid stream of header
// and entry beats into registered write strobes on the long/short
// predefined-table memories and tracks which slots hold a complete table.
module cr_huf_comp_predet_ld
  import cr_huf_compPKG::*;
#(
  parameter int NUM_ID       = PREDET_NUM_ID,
  parameter int LONG_ENTRIES = PREDET_LONG_ENTRIES,
  parameter int SHRT_ENTRIES = PREDET_SHRT_ENTRIES,
  parameter int ENTRY_W      = PREDET_ENTRY_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ld_vld,
  output logic                         ld_rdy,
  input  logic                         ld_sot,
  input  logic [PREDET_LD_W-1:0]       ld_data,
  input  logic [NUM_ID-1:0]            slot_busy,
  output s_sm_predet_mem_intf          sm_predet_mem_long_intf,
  output s_sm_predet_mem_intf          sm_predet_mem_shrt_intf,
  output logic [NUM_ID-1:0]            long_tbl_vld,
  output logic [NUM_ID-1:0]            shrt_tbl_vld,
  output logic                         ld_err
);

  e_predet_ld_state              r_state;
  e_predet_ld_state              w_nxt_state;
  logic [PREDET_ID_W-1:0]        r_id;
  logic [PREDET_ID_W-1:0]        w_nxt_id;
  logic                          r_type;
  logic                          w_nxt_type;
  logic [PREDET_ADDR_W-1:0]      r_cnt;
  logic [PREDET_ADDR_W-1:0]      w_nxt_cnt;
  logic                          r_rdy;
  logic                          r_err;
  logic                          r_done;
  logic [PREDET_ID_W-1:0]        r_done_id;
  logic                          r_done_type;
  logic [NUM_ID-1:0]             r_long_vld;
  logic [NUM_ID-1:0]             r_shrt_vld;
  logic [NUM_ID-1:0]             w_long_vld_nxt;
  logic [NUM_ID-1:0]             w_shrt_vld_nxt;
  s_sm_predet_mem_intf           r_long_intf;
  s_sm_predet_mem_intf           r_shrt_intf;

  logic                          w_acc;
  logic [PREDET_ID_W-1:0]        w_hdr_id;
  logic                          w_hdr_type;
  logic                          w_hdr_ok;
  logic                          w_hdr_busy;
  logic                          w_last;
  logic                          w_hdr;
  logic                          w_wr;
  logic                          w_clr;
  logic                          w_err;
  logic                          w_done;
  logic                          w_unused;

  assign w_acc      = ld_vld & r_rdy;
  assign w_hdr_id   = ld_data[PREDET_HDR_ID_MSB:PREDET_HDR_ID_LSB];
  assign w_hdr_type = ld_data[PREDET_HDR_TYPE_BIT];
  assign w_hdr_ok   = ({1'b0, w_hdr_id} < (PREDET_ID_W+1)'(NUM_ID));
  assign w_hdr_busy = w_hdr_ok & slot_busy[w_hdr_id];
  assign w_last     = (r_cnt == predet_last_idx(r_type, LONG_ENTRIES, SHRT_ENTRIES));
  assign w_unused   = ^ld_data[PREDET_LD_W-1:ENTRY_W];

  // State, header context and entry counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_id    <= '0;
      r_type  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_id    <= w_nxt_id;
      r_type  <= w_nxt_type;
      r_cnt   <= w_nxt_cnt;
    end
  end

  // Next-state decode; any accepted header (fresh or aborting) is handled
  // by the common block after the case so abort and re-header share one path.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_id    = r_id;
    w_nxt_type  = r_type;
    w_nxt_cnt   = r_cnt;
    w_hdr       = 1'b0;
    w_wr        = 1'b0;
    w_clr       = 1'b0;
    w_err       = 1'b0;
    w_done      = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (w_acc) begin
          if (ld_sot) w_hdr = 1'b1;
          else        w_err = 1'b1;
        end
      end
      ST_WAIT_FREE: begin
        if (!slot_busy[r_id]) begin
          w_clr       = 1'b1;
          w_nxt_state = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (w_acc) begin
          if (ld_sot) begin
            w_err = 1'b1;
            w_hdr = 1'b1;
          end else begin
            w_wr      = 1'b1;
            w_nxt_cnt = r_cnt + 1'b1;
            if (w_last) begin
              w_done      = 1'b1;
              w_nxt_state = ST_IDLE;
            end
          end
        end
      end
      ST_DROP: begin
        if (w_acc) begin
          if (ld_sot) begin
            w_err = 1'b1;
            w_hdr = 1'b1;
          end else begin
            w_nxt_cnt = r_cnt + 1'b1;
            if (w_last) w_nxt_state = ST_IDLE;
          end
        end
      end
      default: w_nxt_state = ST_IDLE;
    endcase

    if (w_hdr) begin
      w_nxt_id   = w_hdr_id;
      w_nxt_type = w_hdr_type;
      w_nxt_cnt  = '0;
      if (!w_hdr_ok) begin
        w_err       = 1'b1;
        w_nxt_state = ST_DROP;
      end else if (w_hdr_busy) begin
        w_nxt_state = ST_WAIT_FREE;
      end else begin
        w_clr       = 1'b1;
        w_nxt_state = ST_LOAD;
      end
    end
  end

  // Ready is registered from the next state so it stays low during reset
  // and rises on the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdy <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_rdy <= (w_nxt_state != ST_WAIT_FREE);
      r_err <= w_err;
    end
  end

  // Registered write strobes; only the interface matching the table type fires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_long_intf <= '0;
      r_shrt_intf <= '0;
    end else begin
      r_long_intf.wr <= w_wr & (r_type == PREDET_TYPE_LONG);
      r_shrt_intf.wr <= w_wr & (r_type == PREDET_TYPE_SHRT);
      if (w_wr && (r_type == PREDET_TYPE_LONG)) begin
        r_long_intf.mem_id <= r_id;
        r_long_intf.addr   <= r_cnt;
        r_long_intf.data   <= ld_data[ENTRY_W-1:0];
      end
      if (w_wr && (r_type == PREDET_TYPE_SHRT)) begin
        r_shrt_intf.mem_id <= r_id;
        r_shrt_intf.addr   <= r_cnt;
        r_shrt_intf.data   <= ld_data[ENTRY_W-1:0];
      end
    end
  end

  // Completion marker delayed one cycle so vld follows the final write strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done      <= 1'b0;
      r_done_id   <= '0;
      r_done_type <= 1'b0;
    end else begin
      r_done      <= w_done;
      r_done_id   <= r_id;
      r_done_type <= r_type;
    end
  end

  // Slot valid update: completion sets, a new load on the slot clears (clear wins).
  always_comb begin
    w_long_vld_nxt = r_long_vld;
    w_shrt_vld_nxt = r_shrt_vld;
    if (r_done) begin
      if (r_done_type == PREDET_TYPE_SHRT) w_shrt_vld_nxt[r_done_id] = 1'b1;
      else                                 w_long_vld_nxt[r_done_id] = 1'b1;
    end
    if (w_clr) begin
      if (w_nxt_type == PREDET_TYPE_SHRT) w_shrt_vld_nxt[w_nxt_id] = 1'b0;
      else                                w_long_vld_nxt[w_nxt_id] = 1'b0;
    end
  end

  // Slot valid registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_long_vld <= '0;
      r_shrt_vld <= '0;
    end else begin
      r_long_vld <= w_long_vld_nxt;
      r_shrt_vld <= w_shrt_vld_nxt;
    end
  end

  assign ld_rdy                  = r_rdy;
  assign ld_err                  = r_err;
  assign long_tbl_vld            = r_long_vld;
  assign shrt_tbl_vld            = r_shrt_vld;
  assign sm_predet_mem_long_intf = r_long_intf;
  assign sm_predet_mem_shrt_intf = r_shrt_intf;

endmodule

// File: tb/tb_cr_huf_comp_predet_ld.sv
// Directed self-checking bench for the predefined Huffman table loader.
module tb_cr_huf_comp_predet_ld;
  import cr_huf_compPKG::*;

  typedef struct packed {
    logic [3:0]  id;
    logic [5:0]  addr;
    logic [59:0] data;
  } wr_rec_t;

  logic                clk;
  logic                rst_n;
  logic                ld_vld;
  logic                ld_rdy;
  logic                ld_sot;
  logic [63:0]         ld_data;
  logic [9:0]          slot_busy;
  s_sm_predet_mem_intf lintf;
  s_sm_predet_mem_intf sintf;
  logic [9:0]          lvld;
  logic [9:0]          svld;
  logic                ld_err;

  int      n_chk;
  int      n_fail;
  int      err_cnt;
  wr_rec_t lq[$];
  wr_rec_t sq[$];

  cr_huf_comp_predet_ld #(
    .NUM_ID       (10),
    .LONG_ENTRIES (22),
    .SHRT_ENTRIES (48),
    .ENTRY_W      (60)
  ) u_dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .ld_vld                  (ld_vld),
    .ld_rdy                  (ld_rdy),
    .ld_sot                  (ld_sot),
    .ld_data                 (ld_data),
    .slot_busy               (slot_busy),
    .sm_predet_mem_long_intf (lintf),
    .sm_predet_mem_shrt_intf (sintf),
    .long_tbl_vld            (lvld),
    .shrt_tbl_vld            (svld),
    .ld_err                  (ld_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write and error monitor, sampled mid-cycle.
  always @(negedge clk) begin : mon
    wr_rec_t rec;
    if (lintf.wr) begin
      rec.id = lintf.mem_id; rec.addr = lintf.addr; rec.data = lintf.data;
      lq.push_back(rec);
    end
    if (sintf.wr) begin
      rec.id = sintf.mem_id; rec.addr = sintf.addr; rec.data = sintf.data;
      sq.push_back(rec);
    end
    if (ld_err) err_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_mon();
    lq.delete();
    sq.delete();
    err_cnt = 0;
  endtask

  // Present one beat and hold it until accepted; returns 1 time unit after the accept edge.
  task automatic send_beat(input logic sot, input logic [63:0] d);
    int t;
    ld_vld  = 1'b1;
    ld_sot  = sot;
    ld_data = d;
    t = 0;
    while (!ld_rdy && t < 200) begin @(posedge clk); #1; t++; end
    if (!ld_rdy) chk("rdy_timeout", {63'd0, ld_rdy}, 64'd1);
    @(posedge clk); #1;
    ld_vld = 1'b0;
    ld_sot = 1'b0;
  endtask

  task automatic chk_writes(input bit shrt, input int n, input logic [3:0] id, input logic [59:0] base);
    wr_rec_t rec;
    int      sz;
    sz = shrt ? sq.size() : lq.size();
    chk(shrt ? "sq_count" : "lq_count", 64'(sz), 64'(n));
    for (int i = 0; i < n && i < sz; i++) begin
      rec = shrt ? sq[i] : lq[i];
      chk($sformatf("w_addr[%0d]", i), 64'(rec.addr), 64'(i));
      chk($sformatf("w_id[%0d]", i), 64'(rec.id), 64'(id));
      chk($sformatf("w_data[%0d]", i), 64'(rec.data), 64'(60'(base + 60'(i))));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_fail = 0; err_cnt = 0;
    rst_n = 1'b0; ld_vld = 1'b0; ld_sot = 1'b0; ld_data = '0; slot_busy = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", {63'd0, ld_rdy}, 64'd0);
    chk("rst_lintf", {lintf.wr, lintf.mem_id, lintf.addr}, 64'd0);
    chk("rst_ldata", 64'(lintf.data), 64'd0);
    chk("rst_sintf", {sintf.wr, sintf.mem_id, sintf.addr}, 64'd0);
    chk("rst_lvld", 64'(lvld), 64'd0);
    chk("rst_svld", 64'(svld), 64'd0);
    chk("rst_err", {63'd0, ld_err}, 64'd0);
    rst_n = 1'b1;
    chk("rdy_pre", {63'd0, ld_rdy}, 64'd0);
    idle(1);
    chk("rdy_post", {63'd0, ld_rdy}, 64'd1);

    // Long load id 3, back-to-back, write one cycle after each accept.
    clear_mon();
    send_beat(1'b1, 64'h3);
    chk("t1_hdr_err", {63'd0, ld_err}, 64'd0);
    for (int i = 0; i < 22; i++) begin
      send_beat(1'b0, 64'h100 + 64'(i));
      chk($sformatf("t1_wr[%0d]", i), {63'd0, lintf.wr}, 64'd1);
      chk($sformatf("t1_addr[%0d]", i), 64'(lintf.addr), 64'(i));
      chk($sformatf("t1_data[%0d]", i), 64'(lintf.data), 64'h100 + 64'(i));
      chk($sformatf("t1_swr[%0d]", i), {63'd0, sintf.wr}, 64'd0);
    end
    chk("t1_vld_early", 64'(lvld), 64'd0);
    idle(1);
    chk("t1_vld", 64'(lvld), 64'h008);
    chk("t1_wr_end", {63'd0, lintf.wr}, 64'd0);
    chk("t1_sq_none", 64'(sq.size()), 64'd0);
    chk_writes(1'b0, 22, 4'd3, 60'h100);

    // Short load id 9 with bubbles; upper ld_data bits must be dropped.
    clear_mon();
    send_beat(1'b1, 64'h19);
    for (int i = 0; i < 48; i++) begin
      send_beat(1'b0, {4'hA, 60'h5A000 + 60'(i)});
      if (i % 5 == 2) idle(1);
      if (i % 11 == 0) idle(2);
    end
    idle(1);
    chk("t2_svld", 64'(svld), 64'h200);
    chk("t2_lvld", 64'(lvld), 64'h008);
    chk("t2_lq_none", 64'(lq.size()), 64'd0);
    chk_writes(1'b1, 48, 4'd9, 60'h5A000);

    // Busy stall on slot 5.
    clear_mon();
    slot_busy = 10'h020;
    send_beat(1'b1, 64'h5);
    ld_vld = 1'b1; ld_sot = 1'b0; ld_data = 64'h300;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t3_stall_rdy[%0d]", i), {63'd0, ld_rdy}, 64'd0);
      chk($sformatf("t3_stall_vld[%0d]", i), {63'd0, lvld[5]}, 64'd0);
      idle(1);
    end
    chk("t3_stall_nowr", 64'(lq.size()), 64'd0);
    slot_busy = '0;
    idle(1);
    chk("t3_rdy_release", {63'd0, ld_rdy}, 64'd1);
    for (int i = 0; i < 22; i++) send_beat(1'b0, 64'h300 + 64'(i));
    chk("t3_vld_early", {63'd0, lvld[5]}, 64'd0);
    idle(1);
    chk("t3_lvld", 64'(lvld), 64'h028);
    chk_writes(1'b0, 22, 4'd5, 60'h300);

    // Abort long id 2 after 7 entries by a short header on id 4.
    clear_mon();
    send_beat(1'b1, 64'h2);
    for (int i = 0; i < 7; i++) send_beat(1'b0, 64'h200 + 64'(i));
    send_beat(1'b1, 64'h14);
    chk("t4_abort_err", {63'd0, ld_err}, 64'd1);
    idle(1);
    chk("t4_err_pulse", {63'd0, ld_err}, 64'd0);
    for (int i = 0; i < 48; i++) send_beat(1'b0, 64'h400 + 64'(i));
    idle(1);
    chk("t4_lvld", 64'(lvld), 64'h028);
    chk("t4_svld", 64'(svld), 64'h210);
    chk("t4_err_cnt", 64'(err_cnt), 64'd1);
    chk_writes(1'b0, 7, 4'd2, 60'h200);
    chk_writes(1'b1, 48, 4'd4, 60'h400);

    // Reload id 3: its vld clears on the header.
    clear_mon();
    send_beat(1'b1, 64'h3);
    chk("t5_clr", 64'(lvld), 64'h020);
    for (int i = 0; i < 22; i++) send_beat(1'b0, 64'h500 + 64'(i));
    idle(1);
    chk("t5_lvld", 64'(lvld), 64'h028);

    // Bad id 12: drop 22 beats, then a normal load on id 0.
    clear_mon();
    send_beat(1'b1, 64'hC);
    chk("t6_err", {63'd0, ld_err}, 64'd1);
    for (int i = 0; i < 22; i++) send_beat(1'b0, 64'h6F0 + 64'(i));
    idle(1);
    chk("t6_drop_nowr", 64'(lq.size() + sq.size()), 64'd0);
    chk("t6_drop_vld", 64'(lvld), 64'h028);
    send_beat(1'b1, 64'h0);
    for (int i = 0; i < 22; i++) send_beat(1'b0, 64'h600 + 64'(i));
    idle(1);
    chk("t6_err_cnt", 64'(err_cnt), 64'd1);
    chk("t6_lvld", 64'(lvld), 64'h029);
    chk("t6_svld", 64'(svld), 64'h210);
    chk("t6_sq_none", 64'(sq.size()), 64'd0);
    chk_writes(1'b0, 22, 4'd0, 60'h600);

    // Reset during an id 1 load.
    clear_mon();
    send_beat(1'b1, 64'h1);
    for (int i = 0; i < 10; i++) send_beat(1'b0, 64'h700 + 64'(i));
    rst_n = 1'b0;
    #1;
    chk("t7_rst_rdy", {63'd0, ld_rdy}, 64'd0);
    chk("t7_rst_lvld", 64'(lvld), 64'd0);
    chk("t7_rst_svld", 64'(svld), 64'd0);
    chk("t7_rst_lintf", {lintf.wr, lintf.mem_id, lintf.addr}, 64'd0);
    chk("t7_rst_sintf", {sintf.wr, sintf.mem_id, sintf.addr}, 64'd0);
    chk("t7_rst_err", {63'd0, ld_err}, 64'd0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    clear_mon();
    send_beat(1'b0, 64'h777);
    chk("t7_nohdr_err", {63'd0, ld_err}, 64'd1);
    idle(2);
    chk("t7_nowr", 64'(lq.size() + sq.size()), 64'd0);
    chk("t7_err_cnt", 64'(err_cnt), 64'd1);
    chk("t7_lvld", 64'(lvld), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
